execute_jump_queue: RTL and testbench
=====================================

Name: execute_jump_queue

Overview:
Parametrised successor to the execute-stage jump register. It captures branch and system-register jump results from the execute pipeline into a DEPTH-entry queue, so that a busy consumer does not stall execute immediately. It then presents the results in order to the fetch/redirect logic. After any jump is queued, a wrong-path shadow state discards younger instructions until the front end acknowledges the redirect.

Parameters:
ADDR_W, 32, width of PC and jump address.
DEPTH, 2, queue entries; power of two, >=2.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous flush
iEVENT_HOLD  in  1  event flush
iEVENT_END  in  1  event flush
iSTATE_NORMAL  in  1  core in normal state; when low, flush
iPREV_VALID  in  1  execute result valid
iPREV_EX_BRANCH  in  1  result is a branch instruction
iPREV_EX_SYS_REG  in  1  result is a sysreg instruction
iPREV_PC  in  ADDR_W  fall-through PC
iPREV_BRANCH_PREDICT_ENA  in  1  prediction was made
iPREV_BRANCH_PREDICT_HIT  in  1  prediction hit
iPREV_BRANCH_PREDICT_MISS_VALID  in  1  predicted taken, actually not taken
iPREV_BRANCH_PREDICT_ADDR_MISS_VALID  in  1  taken, predicted address wrong
iPREV_BRANCH_IB_VALID  in  1  interrupt-return style branch
iPREV_BRANCH_ADDR  in  ADDR_W  branch target
iPREV_SYSREG_IDT_VALID / iPREV_SYSREG_PDT_VALID / iPREV_SYSREG_PSR_VALID  in  1 each  sysreg jump kind
iPREV_SYSREG_ADDR  in  ADDR_W  sysreg restart address
oPREV_BUSY  out  1  queue cannot accept
iNEXT_BUSY  in  1  consumer stall
oNEXT_VALID  out  1  head entry valid
oNEXT_PREDICT_ENA / oNEXT_PREDICT_HIT  out  1 each  head predictor info
oNEXT_JUMP_VALID  out  1  head requires redirect
oNEXT_JUMP_ADDR  out  ADDR_W  redirect address
oNEXT_TYPE  out  5  one-hot {PSR,PDT,IDT,IB,BRANCH}
iFRONT_REDIRECT_ACK  in  1  front end has applied redirect
oSHADOW  out  1  wrong-path discard active

Behaviour:
- Reset: all outputs 0; queue empty; FSM in RUN.
- Flush (iRESET_SYNC | iEVENT_HOLD | iEVENT_END | !iSTATE_NORMAL):
  - Empties the queue and forces RUN.
  - Has priority over push, pop and ack.
  - Outputs read 0 from the next cycle.
- Accept = iPREV_VALID & !oPREV_BUSY & no flush.
- Push = accept & RUN & (iPREV_EX_BRANCH | iPREV_EX_SYS_REG). Other accepted results are consumed without being queued.
- Entry fields:
  - predict_ena/hit: taken from input for branches; 0 for sysreg.
  - jump = MISS | ADDR_MISS | IB for branch; jump = IDT | PDT | PSR for sysreg.
  - addr (branch): BRANCH_ADDR if ADDR_MISS or IB, else PC if MISS, else 0. Sysreg: SYSREG_ADDR.
  - type: BRANCH = MISS | ADDR_MISS; IB, IDT, PDT and PSR copied from inputs. Branch inputs are used only for branch results; sysreg inputs only for sysreg results.
- Latency: a pushed entry appears on the outputs one cycle after accept. There is no bypass.
- Output side:
  - oNEXT_VALID = !empty. Head fields are driven when valid; all fields are 0 when empty.
  - Pop = oNEXT_VALID & !iNEXT_BUSY.
- oPREV_BUSY = full & RUN. Push while full is impossible. Simultaneous push and pop when not full leaves the count unchanged.
- Pointers wrap modulo DEPTH. The count is clog2(DEPTH)+1 bits wide.
- FSM:
  - RUN -> SHADOW on a push with jump=1.
  - SHADOW -> RUN on iFRONT_REDIRECT_ACK.
  - In SHADOW, every accepted result is discarded, including one arriving in the same cycle as the ack.
  - Ack in RUN is ignored.
  - oSHADOW = (state==SHADOW).
- The queue keeps draining during SHADOW.

Optional Feature:
EXECUTE_JUMP_QUEUE_STAT_EN
- Defined: adds ports oSTAT_JUMP_COUNT[31:0] and oSTAT_SHADOW_DROP_COUNT[31:0].
  - oSTAT_JUMP_COUNT increments on each jump push.
  - oSTAT_SHADOW_DROP_COUNT increments on each accept discarded in SHADOW.
  - Both wrap at 2^32 and are cleared only by inRESET; flushes do not clear them.
- Undefined: the ports and counters are absent.

Decomposition:
- Package execute_jump_pkg:
  - localparam bit indices for the 5-bit type.
  - typedef jump_type_t (logic [4:0]).
  - FSM enum {RUN, SHADOW}.
- The entry record is a packed vector built locally, because its width depends on ADDR_W.
- Sub-module execute_jump_fifo (parameters W, DEPTH): push, pop, flush, empty, full, head.

Test Plan:
1. Branch, ADDR_MISS=1, BRANCH_ADDR=0x0000_1000, iNEXT_BUSY=0 -> next cycle oNEXT_VALID=1, JUMP_VALID=1, JUMP_ADDR=0x1000, TYPE=5'b00001, oSHADOW=1.
2. Branch, MISS=1, PC=0x0000_0204 -> JUMP_ADDR=0x204. Three further valid results before ack -> not queued (drop count=3 with macro). Ack -> oSHADOW=0.
3. iNEXT_BUSY=1, DEPTH=2, two non-jump branches (PREDICT_ENA=1, HIT=1) -> oPREV_BUSY=1 after the 2nd. Release busy -> entries pop in order on consecutive cycles, then oNEXT_VALID=0.
4. Sysreg with PSR=1, SYSREG_ADDR=0x8000_0000 -> TYPE=5'b10000, JUMP_ADDR=0x8000_0000, PREDICT_ENA=0.
5. Queue holding 2 entries in SHADOW, then iEVENT_HOLD pulse -> next cycle oNEXT_VALID=0, oSHADOW=0, all outputs 0; stat counters unchanged.
6. inRESET asserted mid-push -> all outputs 0 immediately (asynchronous); after release, first accepted branch is queued normally.

Source files
------------

// File: rtl/execute_jump_pkg.sv
// Shared types for the execute-stage jump queue: type-vector bit indices,
// the jump type vector and the wrong-path FSM states.
package execute_jump_pkg;

   localparam int unsigned TYPE_W      = 5;
   localparam int unsigned TYPE_BRANCH = 0;
   localparam int unsigned TYPE_IB     = 1;
   localparam int unsigned TYPE_IDT    = 2;
   localparam int unsigned TYPE_PDT    = 3;
   localparam int unsigned TYPE_PSR    = 4;

   typedef logic [TYPE_W-1:0] jump_type_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SHADOW = 1'b1
   } jq_state_t;

endpackage

// File: rtl/execute_jump_queue_if.sv
// Execute-result input side and redirect output side of the jump queue.
interface execute_jump_queue_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              iPREV_VALID;
   logic              iPREV_EX_BRANCH;
   logic              iPREV_EX_SYS_REG;
   logic [ADDR_W-1:0] iPREV_PC;
   logic              iPREV_BRANCH_PREDICT_ENA;
   logic              iPREV_BRANCH_PREDICT_HIT;
   logic              iPREV_BRANCH_PREDICT_MISS_VALID;
   logic              iPREV_BRANCH_PREDICT_ADDR_MISS_VALID;
   logic              iPREV_BRANCH_IB_VALID;
   logic [ADDR_W-1:0] iPREV_BRANCH_ADDR;
   logic              iPREV_SYSREG_IDT_VALID;
   logic              iPREV_SYSREG_PDT_VALID;
   logic              iPREV_SYSREG_PSR_VALID;
   logic [ADDR_W-1:0] iPREV_SYSREG_ADDR;
   logic              oPREV_BUSY;
   logic              iNEXT_BUSY;
   logic              oNEXT_VALID;
   logic              oNEXT_PREDICT_ENA;
   logic              oNEXT_PREDICT_HIT;
   logic              oNEXT_JUMP_VALID;
   logic [ADDR_W-1:0] oNEXT_JUMP_ADDR;
   logic [4:0]        oNEXT_TYPE;
   logic              iFRONT_REDIRECT_ACK;
   logic              oSHADOW;

   modport master (
      output iPREV_VALID, iPREV_EX_BRANCH, iPREV_EX_SYS_REG, iPREV_PC,
             iPREV_BRANCH_PREDICT_ENA, iPREV_BRANCH_PREDICT_HIT,
             iPREV_BRANCH_PREDICT_MISS_VALID, iPREV_BRANCH_PREDICT_ADDR_MISS_VALID,
             iPREV_BRANCH_IB_VALID, iPREV_BRANCH_ADDR,
             iPREV_SYSREG_IDT_VALID, iPREV_SYSREG_PDT_VALID, iPREV_SYSREG_PSR_VALID,
             iPREV_SYSREG_ADDR, iNEXT_BUSY, iFRONT_REDIRECT_ACK,
      input  oPREV_BUSY, oNEXT_VALID, oNEXT_PREDICT_ENA, oNEXT_PREDICT_HIT,
             oNEXT_JUMP_VALID, oNEXT_JUMP_ADDR, oNEXT_TYPE, oSHADOW
   );

   modport slave (
      input  iPREV_VALID, iPREV_EX_BRANCH, iPREV_EX_SYS_REG, iPREV_PC,
             iPREV_BRANCH_PREDICT_ENA, iPREV_BRANCH_PREDICT_HIT,
             iPREV_BRANCH_PREDICT_MISS_VALID, iPREV_BRANCH_PREDICT_ADDR_MISS_VALID,
             iPREV_BRANCH_IB_VALID, iPREV_BRANCH_ADDR,
             iPREV_SYSREG_IDT_VALID, iPREV_SYSREG_PDT_VALID, iPREV_SYSREG_PSR_VALID,
             iPREV_SYSREG_ADDR, iNEXT_BUSY, iFRONT_REDIRECT_ACK,
      output oPREV_BUSY, oNEXT_VALID, oNEXT_PREDICT_ENA, oNEXT_PREDICT_HIT,
             oNEXT_JUMP_VALID, oNEXT_JUMP_ADDR, oNEXT_TYPE, oSHADOW
   );
endinterface

// File: rtl/execute_jump_fifo.sv
// Small register FIFO holding packed jump entries; flush empties it in one cycle.
module execute_jump_fifo #(
   parameter int unsigned W     = 40,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         empty_o,
   output logic         full_o,
   output logic [W-1:0] head_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == CW'(0));
   assign full_o  = (count_q == CW'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Storage, power-of-two wrapping pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/execute_jump_queue.sv
// Execute-stage jump queue: buffers branch/sysreg results for the redirect
// logic and discards wrong-path results until the front end acknowledges.
// Optional statistics counters: define EXECUTE_JUMP_QUEUE_STAT_EN.
module execute_jump_queue
   import execute_jump_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic iCLOCK,
   input  logic inRESET,
   input  logic iRESET_SYNC,
   input  logic iEVENT_HOLD,
   input  logic iEVENT_END,
   input  logic iSTATE_NORMAL,
   execute_jump_queue_if.slave bus
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
   ,
   output logic [31:0] oSTAT_JUMP_COUNT,
   output logic [31:0] oSTAT_SHADOW_DROP_COUNT
`endif
);
   // Entry layout: {predict_ena, predict_hit, jump, addr, type}
   localparam int unsigned ENT_W = ADDR_W + 3 + TYPE_W;

   jq_state_t        state_q, state_d;
   logic             flush_c, busy_c, accept_c, push_c, pop_c;
   logic             empty, full;
   logic [ENT_W-1:0] entry_c, head;
   logic             ent_pe, ent_ph, ent_jump;
   logic [ADDR_W-1:0] ent_addr;
   jump_type_t       ent_type;

   assign flush_c  = iRESET_SYNC | iEVENT_HOLD | iEVENT_END | ~iSTATE_NORMAL;
   assign busy_c   = full & (state_q == ST_RUN);
   assign accept_c = bus.iPREV_VALID & ~busy_c & ~flush_c;
   assign push_c   = accept_c & (state_q == ST_RUN) &
                     (bus.iPREV_EX_BRANCH | bus.iPREV_EX_SYS_REG);
   assign pop_c    = ~empty & ~bus.iNEXT_BUSY;

   // Build the queue entry from the execute result; branch takes precedence
   always_comb begin
      ent_pe   = 1'b0;
      ent_ph   = 1'b0;
      ent_jump = 1'b0;
      ent_addr = '0;
      ent_type = '0;
      if (bus.iPREV_EX_BRANCH) begin
         ent_pe   = bus.iPREV_BRANCH_PREDICT_ENA;
         ent_ph   = bus.iPREV_BRANCH_PREDICT_HIT;
         ent_jump = bus.iPREV_BRANCH_PREDICT_MISS_VALID |
                    bus.iPREV_BRANCH_PREDICT_ADDR_MISS_VALID | bus.iPREV_BRANCH_IB_VALID;
         if (bus.iPREV_BRANCH_PREDICT_ADDR_MISS_VALID | bus.iPREV_BRANCH_IB_VALID)
            ent_addr = bus.iPREV_BRANCH_ADDR;
         else if (bus.iPREV_BRANCH_PREDICT_MISS_VALID)
            ent_addr = bus.iPREV_PC;
         ent_type[TYPE_BRANCH] = bus.iPREV_BRANCH_PREDICT_MISS_VALID |
                                 bus.iPREV_BRANCH_PREDICT_ADDR_MISS_VALID;
         ent_type[TYPE_IB]     = bus.iPREV_BRANCH_IB_VALID;
      end else if (bus.iPREV_EX_SYS_REG) begin
         ent_jump = bus.iPREV_SYSREG_IDT_VALID | bus.iPREV_SYSREG_PDT_VALID |
                    bus.iPREV_SYSREG_PSR_VALID;
         ent_addr = bus.iPREV_SYSREG_ADDR;
         ent_type[TYPE_IDT] = bus.iPREV_SYSREG_IDT_VALID;
         ent_type[TYPE_PDT] = bus.iPREV_SYSREG_PDT_VALID;
         ent_type[TYPE_PSR] = bus.iPREV_SYSREG_PSR_VALID;
      end
      entry_c = {ent_pe, ent_ph, ent_jump, ent_addr, ent_type};
   end

   execute_jump_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (iCLOCK),
      .rst_n   (inRESET),
      .flush_i (flush_c),
      .push_i  (push_c),
      .data_i  (entry_c),
      .pop_i   (pop_c),
      .empty_o (empty),
      .full_o  (full),
      .head_o  (head)
   );

   // Wrong-path state register
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   // Enter shadow on a queued jump, leave on redirect ack; flush forces RUN
   always_comb begin
      state_d = state_q;
      if (flush_c) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:    if (push_c & ent_jump) state_d = ST_SHADOW;
            ST_SHADOW: if (bus.iFRONT_REDIRECT_ACK) state_d = ST_RUN;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // Head fields gated to zero while the queue is empty
   always_comb begin
      bus.oPREV_BUSY        = busy_c;
      bus.oSHADOW           = (state_q == ST_SHADOW);
      bus.oNEXT_VALID       = ~empty;
      bus.oNEXT_PREDICT_ENA = 1'b0;
      bus.oNEXT_PREDICT_HIT = 1'b0;
      bus.oNEXT_JUMP_VALID  = 1'b0;
      bus.oNEXT_JUMP_ADDR   = '0;
      bus.oNEXT_TYPE        = '0;
      if (!empty) begin
         bus.oNEXT_PREDICT_ENA = head[ENT_W-1];
         bus.oNEXT_PREDICT_HIT = head[ENT_W-2];
         bus.oNEXT_JUMP_VALID  = head[ENT_W-3];
         bus.oNEXT_JUMP_ADDR   = head[ENT_W-4 -: ADDR_W];
         bus.oNEXT_TYPE        = head[TYPE_W-1:0];
      end
   end

`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
   // Jump and shadow-drop counters; cleared only by the async reset
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         oSTAT_JUMP_COUNT        <= '0;
         oSTAT_SHADOW_DROP_COUNT <= '0;
      end else begin
         if (push_c & ent_jump)
            oSTAT_JUMP_COUNT <= oSTAT_JUMP_COUNT + 32'(1);
         if (accept_c & (state_q == ST_SHADOW))
            oSTAT_SHADOW_DROP_COUNT <= oSTAT_SHADOW_DROP_COUNT + 32'(1);
      end
   end
`endif
endmodule

// File: tb/tb_execute_jump_queue.sv
// Directed self-checking bench for execute_jump_queue (DEPTH=2, ADDR_W=32).
module tb_execute_jump_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rsync = 1'b0, hold = 1'b0, evend = 1'b0, normal = 1'b1;
   int   checks = 0;
   int   failures = 0;
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
   logic [31:0] stat_jump, stat_drop;
`endif

   execute_jump_queue_if #(.ADDR_W(32)) bus();

   execute_jump_queue #(.ADDR_W(32), .DEPTH(2)) dut (
      .iCLOCK        (clk),
      .inRESET       (rst_n),
      .iRESET_SYNC   (rsync),
      .iEVENT_HOLD   (hold),
      .iEVENT_END    (evend),
      .iSTATE_NORMAL (normal),
      .bus           (bus)
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
      ,
      .oSTAT_JUMP_COUNT        (stat_jump),
      .oSTAT_SHADOW_DROP_COUNT (stat_drop)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.iPREV_VALID = 0; bus.iPREV_EX_BRANCH = 0; bus.iPREV_EX_SYS_REG = 0;
      bus.iPREV_PC = '0; bus.iPREV_BRANCH_PREDICT_ENA = 0; bus.iPREV_BRANCH_PREDICT_HIT = 0;
      bus.iPREV_BRANCH_PREDICT_MISS_VALID = 0; bus.iPREV_BRANCH_PREDICT_ADDR_MISS_VALID = 0;
      bus.iPREV_BRANCH_IB_VALID = 0; bus.iPREV_BRANCH_ADDR = '0;
      bus.iPREV_SYSREG_IDT_VALID = 0; bus.iPREV_SYSREG_PDT_VALID = 0;
      bus.iPREV_SYSREG_PSR_VALID = 0; bus.iPREV_SYSREG_ADDR = '0;
   endtask

   task automatic branch(input logic pe, input logic ph, input logic miss, input logic amiss,
                         input logic ib, input logic [31:0] pc, input logic [31:0] baddr);
      idle();
      bus.iPREV_VALID = 1; bus.iPREV_EX_BRANCH = 1; bus.iPREV_PC = pc;
      bus.iPREV_BRANCH_PREDICT_ENA = pe; bus.iPREV_BRANCH_PREDICT_HIT = ph;
      bus.iPREV_BRANCH_PREDICT_MISS_VALID = miss;
      bus.iPREV_BRANCH_PREDICT_ADDR_MISS_VALID = amiss;
      bus.iPREV_BRANCH_IB_VALID = ib; bus.iPREV_BRANCH_ADDR = baddr;
   endtask

   // Packed view of the head: {valid, pe, ph, jump, type, addr}
   function automatic logic [63:0] head();
      return {24'd0, bus.oNEXT_VALID, bus.oNEXT_PREDICT_ENA, bus.oNEXT_PREDICT_HIT,
              bus.oNEXT_JUMP_VALID, 1'b0, bus.oNEXT_TYPE, bus.oNEXT_JUMP_ADDR};
   endfunction

   function automatic logic [63:0] hv(input logic v, input logic pe, input logic ph,
                                      input logic j, input logic [4:0] t, input logic [31:0] a);
      return {24'd0, v, pe, ph, j, 1'b0, t, a};
   endfunction

   initial begin
      idle();
      bus.iNEXT_BUSY = 0;
      bus.iFRONT_REDIRECT_ACK = 0;
      repeat (3) @(negedge clk);
      chk("reset_head", head(), 64'd0);
      chk("reset_busy", 64'(bus.oPREV_BUSY), 64'd0);
      chk("reset_shadow", 64'(bus.oSHADOW), 64'd0);
      rst_n = 1;

      // 1: address-miss branch
      step();
      branch(0, 0, 0, 1, 0, 32'h0, 32'h0000_1000);
      step();
      chk("t1_head", head(), hv(1, 0, 0, 1, 5'b00001, 32'h1000));
      chk("t1_shadow", 64'(bus.oSHADOW), 64'd1);
      idle();
      step();
      chk("t1_drained", head(), 64'd0);
      bus.iFRONT_REDIRECT_ACK = 1;
      step();
      bus.iFRONT_REDIRECT_ACK = 0;
      chk("t1_ack", 64'(bus.oSHADOW), 64'd0);

      // 2: mispredict-taken branch, then wrong-path results discarded
      branch(1, 0, 1, 0, 0, 32'h0000_0204, 32'h0000_9999);
      step();
      chk("t2_head", head(), hv(1, 1, 0, 1, 5'b00001, 32'h204));
      branch(1, 1, 0, 1, 0, 32'h10, 32'h2000);
      step();
      step();
      step();
      chk("t2_dropped", head(), 64'd0);
      chk("t2_shadow", 64'(bus.oSHADOW), 64'd1);
      bus.iFRONT_REDIRECT_ACK = 1;
      step();
      bus.iFRONT_REDIRECT_ACK = 0;
      idle();
      chk("t2_ack", 64'(bus.oSHADOW), 64'd0);
      chk("t2_ack_cycle_drop", head(), 64'd0);
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
      chk("t2_stat_drop", 64'(stat_drop), 64'd4);
      chk("t2_stat_jump", 64'(stat_jump), 64'd2);
`endif

      // 3: backpressure with two non-jump branches
      bus.iNEXT_BUSY = 1;
      branch(1, 1, 0, 0, 0, 32'h300, 32'h0);
      step();
      chk("t3_one_busy", 64'(bus.oPREV_BUSY), 64'd0);
      branch(1, 0, 0, 0, 0, 32'h304, 32'h0);
      step();
      chk("t3_full_busy", 64'(bus.oPREV_BUSY), 64'd1);
      branch(0, 0, 0, 1, 0, 32'h308, 32'h5000);
      step();
      chk("t3_refused_head", head(), hv(1, 1, 1, 0, 5'b0, 32'h0));
      chk("t3_refused_shadow", 64'(bus.oSHADOW), 64'd0);
      idle();
      bus.iNEXT_BUSY = 0;
      step();
      chk("t3_second", head(), hv(1, 1, 0, 0, 5'b0, 32'h0));
      chk("t3_not_busy", 64'(bus.oPREV_BUSY), 64'd0);
      step();
      chk("t3_empty", head(), 64'd0);

      // 4: PSR sysreg jump; branch predictor inputs must be ignored
      idle();
      bus.iPREV_VALID = 1; bus.iPREV_EX_SYS_REG = 1;
      bus.iPREV_SYSREG_PSR_VALID = 1; bus.iPREV_SYSREG_ADDR = 32'h8000_0000;
      bus.iPREV_BRANCH_PREDICT_ENA = 1; bus.iPREV_BRANCH_PREDICT_HIT = 1;
      bus.iPREV_BRANCH_IB_VALID = 1; bus.iPREV_BRANCH_ADDR = 32'h7777;
      step();
      chk("t4_head", head(), hv(1, 0, 0, 1, 5'b10000, 32'h8000_0000));
      chk("t4_shadow", 64'(bus.oSHADOW), 64'd1);
      idle();
      bus.iFRONT_REDIRECT_ACK = 1;
      step();
      bus.iFRONT_REDIRECT_ACK = 0;
      chk("t4_done", head(), 64'd0);
      chk("t4_run", 64'(bus.oSHADOW), 64'd0);

      // 5: full queue in shadow, then event flush with a competing push
      bus.iNEXT_BUSY = 1;
      branch(1, 1, 0, 0, 0, 32'h400, 32'h0);
      step();
      branch(0, 0, 0, 0, 1, 32'h404, 32'h0000_0300);
      step();
      chk("t5_full_head", head(), hv(1, 1, 1, 0, 5'b0, 32'h0));
      chk("t5_shadow", 64'(bus.oSHADOW), 64'd1);
      chk("t5_full_shadow_busy", 64'(bus.oPREV_BUSY), 64'd0);
      branch(0, 0, 0, 1, 0, 32'h408, 32'h6000);
      hold = 1;
      step();
      hold = 0;
      idle();
      chk("t5_flush_head", head(), 64'd0);
      chk("t5_flush_shadow", 64'(bus.oSHADOW), 64'd0);
      chk("t5_flush_busy", 64'(bus.oPREV_BUSY), 64'd0);
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
      chk("t5_stat_jump", 64'(stat_jump), 64'd4);
      chk("t5_stat_drop", 64'(stat_drop), 64'd4);
`endif
      bus.iNEXT_BUSY = 0;
      normal = 0;
      branch(0, 0, 1, 0, 0, 32'h500, 32'h0);
      step();
      normal = 1;
      idle();
      chk("t5_not_normal_flush", head(), 64'd0);

      // 6: async reset while an entry is held and a push is offered
      bus.iNEXT_BUSY = 1;
      branch(0, 0, 0, 1, 0, 32'h0, 32'h0000_1000);
      step();
      chk("t6_pre_head", head(), hv(1, 0, 0, 1, 5'b00001, 32'h1000));
      #2;
      rst_n = 0;
      #1;
      chk("t6_async_head", head(), 64'd0);
      chk("t6_async_shadow", 64'(bus.oSHADOW), 64'd0);
`ifdef EXECUTE_JUMP_QUEUE_STAT_EN
      chk("t6_async_stat", 64'({stat_jump, stat_drop}), 64'd0);
`endif
      idle();
      bus.iNEXT_BUSY = 0;
      @(negedge clk);
      rst_n = 1;
      branch(0, 0, 1, 0, 0, 32'h0000_0404, 32'h0);
      step();
      chk("t6_after_head", head(), hv(1, 0, 0, 1, 5'b00001, 32'h404));
      chk("t6_after_shadow", 64'(bus.oSHADOW), 64'd1);
      idle();
      step();
      chk("t6_drained", head(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
